rom_loader_wb_bridge: RTL and testbench



---
 rtl/rom_loader_wb_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_rom_loader_wb_bridge.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader_wb_bridge.sv
// Wishbone-fed FIFO that streams 16-bit Hack words to the hack_soc ROM loader with a 4-phase load/ack handshake.
// Latency: wbs_ack_o one cycle after selection; first word reaches the loader one cycle after it becomes eligible.
// Backpressure: the bus is never stalled. A DATA write to a full FIFO is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk, reset                  : single clock, synchronous active-high reset
//   wbs_*                       : Wishbone slave. Registers: 0 DATA(W), 1 CTRL(RW), 2 STATUS(R), 3 reserved
//   rom_loader_reset            : CTRL.loader_reset, held high out of reset
//   rom_loader_load/_data/_ack  : per-word request, word and acknowledge to/from hack_soc
//   rom_loader_load_received    : hack_soc status bit, reported in STATUS[5]
module rom_loader_wb_bridge #(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int          DEPTH          = 8,
    parameter int          TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        rom_loader_reset,
    output logic        rom_loader_load,
    output logic [15:0] rom_loader_data,
    input  logic        rom_loader_ack,
    input  logic        rom_loader_load_received
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_REL  = 2'd2
    } state_e;

    // ---------------------------------------------------------------
    // Bus decode
    // ---------------------------------------------------------------
    logic        sel;
    logic        acc;
    logic [1:0]  off;
    logic        wr_data;
    logic        wr_ctrl;
    logic        clr_err;
    logic        flush;
    logic        ack_q;
    logic [31:0] dat_q;
    logic [31:0] rdata;

    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i[31:16]};

    assign sel = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // An access is accepted only when no ack went out in this cycle, so a
    // strobe held high produces one transaction per ack.
    assign acc     = sel & ~ack_q;
    assign off     = wbs_adr_i[3:2];
    assign wr_data = acc & wbs_we_i & (off == 2'd0);
    assign wr_ctrl = acc & wbs_we_i & (off == 2'd1);
    assign clr_err = wr_ctrl & wbs_dat_i[2];
    assign flush   = wr_ctrl & wbs_dat_i[3];

    // ---------------------------------------------------------------
    // Control / sticky status
    // ---------------------------------------------------------------
    logic lr_q, en_q, ovf_q, tmo_q;
    logic ovf_set, tmo_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            lr_q  <= 1'b1;
            en_q  <= 1'b0;
            ovf_q <= 1'b0;
            tmo_q <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                lr_q <= wbs_dat_i[0];
                en_q <= wbs_dat_i[1];
            end
            // A new event in the same cycle as clear_err leaves the flag set.
            ovf_q <= (ovf_q & ~clr_err) | ovf_set;
            tmo_q <= (tmo_q & ~clr_err) | tmo_set;
        end
    end

    // ---------------------------------------------------------------
    // FIFO
    // ---------------------------------------------------------------
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          empty, full, push_ok, pop;
    logic [15:0]   data_q;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = wr_data & (~full | pop);
    assign ovf_set = wr_data & ~push_ok;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wbs_dat_i[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + LW'(push_ok) - LW'(pop);
        end
    end

    // The popped word lives here for the whole handshake, so a flush
    // during a transfer does not disturb the word on the wire.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (pop) begin
            data_q <= mem_q[rd_ptr_q];
        end
    end

    // ---------------------------------------------------------------
    // Handshake FSM
    // ---------------------------------------------------------------
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          abort, tmo_hit, start, busy, load;

    assign abort   = lr_q | ~en_q;
    assign tmo_hit = (cnt_q == CW'(TIMEOUT_CYCLES));
    assign start   = en_q & ~lr_q & ~empty & ~rom_loader_ack & ~tmo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_REQ;
            S_REQ: begin
                if (abort || tmo_hit)    state_d = S_IDLE;
                else if (rom_loader_ack) state_d = S_REL;
            end
            S_REL: begin
                if (abort || tmo_hit || !rom_loader_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // load is built only from registered state, so it drops in the same
    // cycle an abort or timeout becomes visible.
    always_comb begin
        busy    = (state_q != S_IDLE);
        load    = (state_q == S_REQ) & ~abort & ~tmo_hit;
        pop     = (state_q == S_IDLE) & start;
        tmo_set = busy & ~abort & tmo_hit;
    end

    // Wait counter: zero on every state entry, counts in REQ and REL.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if ((state_d != state_q) || (state_q == S_IDLE)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // ---------------------------------------------------------------
    // Read mux and bus response
    // ---------------------------------------------------------------
    always_comb begin
        rdata = '0;
        case (off)
            2'd1: rdata = {30'd0, en_q, lr_q};
            2'd2: rdata = {16'd0, 8'(level_q), 2'b00, rom_loader_load_received,
                           tmo_q, ovf_q, busy, full, empty};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= acc;
            dat_q <= (acc && !wbs_we_i) ? rdata : 32'd0;
        end
    end

    assign wbs_ack_o        = ack_q;
    assign wbs_dat_o        = dat_q;
    assign rom_loader_reset = lr_q;
    assign rom_loader_load  = load;
    assign rom_loader_data  = data_q;

endmodule

// File: tb/tb_rom_loader_wb_bridge.sv
// Bench for rom_loader_wb_bridge: register-map vector table plus directed handshake, overflow, timeout and abort sequences.
// Latency: n/a (testbench).
// Backpressure: a behavioural loader answers load one cycle later, or never when silent mode is selected.
module tb_rom_loader_wb_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk;
    logic        reset;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        ld_reset, ld_load, ld_ack, ld_recv;
    logic [15:0] ld_data;

    int n_vec = 0;
    int n_bad = 0;

    rom_loader_wb_bridge #(
        .BASE_ADDR(BASE),
        .DEPTH(8),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i(we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .rom_loader_reset(ld_reset),
        .rom_loader_load(ld_load),
        .rom_loader_data(ld_data),
        .rom_loader_ack(ld_ack),
        .rom_loader_load_received(ld_recv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Loader model: ack follows load one cycle later unless silent.
    bit          silent = 1'b0;
    logic [15:0] cap [$];
    bit          unstable = 1'b0;
    logic        prev_load = 1'b0;
    logic [15:0] held = '0;

    initial begin
        ld_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ld_load && !prev_load) cap.push_back(ld_data);
            if (ld_load && prev_load && ld_data != held) unstable = 1'b1;
            if (ld_load) held = ld_data;
            prev_load = ld_load;
            ld_ack = silent ? 1'b0 : ld_load;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb(input logic w, input logic [1:0] o, input logic [31:0] d,
                      output logic [31:0] r);
        bit got;
        @(posedge clk);
        #1;
        stb = 1'b1; cyc = 1'b1; we = w;
        adr = BASE | {28'd0, o, 2'b00};
        wdat = d;
        got = 1'b0;
        r = '0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                got = 1'b1;
                r = rdat;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL bus_ack: got no ack required ack within 8 cycles (off %0d)", o);
        end
    endtask

    task automatic wr(input logic [1:0] o, input logic [31:0] d);
        logic [31:0] r;
        wb(1'b1, o, d, r);
    endtask

    task automatic rd(input logic [1:0] o, output logic [31:0] r);
        wb(1'b0, o, 32'd0, r);
    endtask

    // Polls STATUS until empty and not busy; an expired bound is a miscompare.
    task automatic wait_idle(input string name);
        logic [31:0] s;
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            rd(2'd2, s);
            if (s[0] && !s[2]) done = 1'b1;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic wait_load_rise(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (ld_load) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    typedef struct {
        string       name;
        logic        w;
        logic [1:0]  o;
        logic [31:0] d;
        logic        recv;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [31:0] r;
        int          base, cnt, acks;
        logic [4:0]  pat;
        logic [31:0] dv [6];

        tbl[0]  = '{"rst_status",   1'b0, 2'd2, 32'd0,         1'b0, 32'h0000_0001};
        tbl[1]  = '{"rst_ctrl",     1'b0, 2'd1, 32'd0,         1'b0, 32'h0000_0001};
        tbl[2]  = '{"data_reads_0", 1'b0, 2'd0, 32'd0,         1'b0, 32'h0000_0000};
        tbl[3]  = '{"off3_reads_0", 1'b0, 2'd3, 32'd0,         1'b0, 32'h0000_0000};
        tbl[4]  = '{"off3_write",   1'b1, 2'd3, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
        tbl[5]  = '{"ctrl_keep",    1'b0, 2'd1, 32'd0,         1'b0, 32'h0000_0001};
        tbl[6]  = '{"ctrl_wr_f",    1'b1, 2'd1, 32'h0000_000F, 1'b0, 32'h0000_0000};
        tbl[7]  = '{"ctrl_rd_3",    1'b0, 2'd1, 32'd0,         1'b0, 32'h0000_0003};
        tbl[8]  = '{"status_recv",  1'b0, 2'd2, 32'd0,         1'b1, 32'h0000_0021};
        tbl[9]  = '{"ctrl_wr_1",    1'b1, 2'd1, 32'h0000_0001, 1'b0, 32'h0000_0000};
        tbl[10] = '{"ctrl_rd_1",    1'b0, 2'd1, 32'd0,         1'b0, 32'h0000_0001};

        reset = 1'b1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        sel = 4'hF; adr = '0; wdat = '0; ld_recv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state of outputs
        chk("rst_ack",       32'(ack),      32'd0);
        chk("rst_dat",       rdat,          32'd0);
        chk("rst_ld_reset",  32'(ld_reset), 32'd1);
        chk("rst_ld_load",   32'(ld_load),  32'd0);
        chk("rst_ld_data",   32'(ld_data),  32'd0);

        // Register map vectors
        for (int i = 0; i < 11; i++) begin
            ld_recv = tbl[i].recv;
            wb(tbl[i].w, tbl[i].o, tbl[i].d, r);
            if (!tbl[i].w) chk(tbl[i].name, r, tbl[i].exp);
        end
        ld_recv = 1'b0;

        // Two words streamed in order through the handshake
        base = cap.size();
        wr(2'd1, 32'h2);
        chk("ld_reset_cleared", 32'(ld_reset), 32'd0);
        wr(2'd0, 32'hDEAD_1234);
        wr(2'd0, 32'h0000_ABCD);
        wait_idle("xfer_idle");
        chk("xfer_count", 32'(cap.size() - base), 32'd2);
        if (cap.size() >= base + 2) begin
            chk("xfer_word0", 32'(cap[base]),     32'h1234);
            chk("xfer_word1", 32'(cap[base + 1]), 32'hABCD);
        end
        chk("xfer_stable", 32'(unstable), 32'd0);
        rd(2'd2, r);
        chk("xfer_status", r, 32'h0000_0001);
        chk("data_hold_idle", 32'(ld_data), 32'hABCD);

        // Overflow with the FSM disabled
        wr(2'd1, 32'h0);
        for (int i = 0; i < 9; i++) wr(2'd0, 32'h100 + i);
        rd(2'd2, r);
        chk("ovf_status", r, 32'h0000_080A);
        wr(2'd1, 32'h4);
        rd(2'd2, r);
        chk("ovf_cleared", r, 32'h0000_0802);
        wr(2'd1, 32'h8);
        rd(2'd2, r);
        chk("flush_empty", r, 32'h0000_0001);

        // Timeout with a silent loader
        silent = 1'b1;
        wr(2'd0, 32'h5555);
        wr(2'd0, 32'h6666);
        base = cap.size();
        wr(2'd1, 32'h2);
        wait_load_rise("tmo_load_rise");
        cnt = 0;
        for (int i = 0; i < 40 && ld_load; i++) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("tmo_load_cycles", 32'(cnt), 32'd15);
        rd(2'd2, r);
        chk("tmo_status", r, 32'h0000_0110);
        repeat (20) @(posedge clk);
        #1;
        chk("tmo_no_reload", 32'(ld_load), 32'd0);
        rd(2'd2, r);
        chk("tmo_head_kept", r, 32'h0000_0110);
        silent = 1'b0;
        wr(2'd1, 32'h6);
        wait_idle("tmo_recover_idle");
        chk("tmo_recover_count", 32'(cap.size() - base), 32'd2);
        if (cap.size() >= base + 2) chk("tmo_recover_word", 32'(cap[base + 1]), 32'h6666);
        rd(2'd2, r);
        chk("tmo_recover_status", r, 32'h0000_0001);

        // Abort mid-REQ with loader_reset
        silent = 1'b1;
        wr(2'd1, 32'h0);
        wr(2'd0, 32'h7777);
        wr(2'd0, 32'h8888);
        wr(2'd1, 32'h2);
        wait_load_rise("abort_load_rise");
        wr(2'd1, 32'h3);
        chk("abort_load_drop", 32'(ld_load),  32'd0);
        chk("abort_ld_reset",  32'(ld_reset), 32'd1);
        rd(2'd2, r);
        chk("abort_status", r, 32'h0000_0100);
        silent = 1'b0;
        wr(2'd1, 32'h8);
        rd(2'd2, r);
        chk("abort_flush", r, 32'h0000_0001);

        // Strobe held for 5 cycles: one ack per transaction
        @(posedge clk);
        #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE | 32'h8;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            pat[5 - i] = ack;
            dv[i] = rdat;
        end
        @(posedge clk);
        #1;
        stb = 1'b0; cyc = 1'b0;
        chk("hold_ack_pattern", 32'(pat), 32'b01010);
        chk("hold_dat_with_ack", dv[2], 32'h0000_0001);
        chk("hold_dat_no_ack",   dv[3], 32'h0000_0000);
        repeat (3) @(posedge clk);

        // Non-matching address
        #1;
        stb = 1'b1; cyc = 1'b1; adr = BASE + 32'h100;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        stb = 1'b0; cyc = 1'b0;
        chk("bad_addr_acks", 32'(acks), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
